// File: rtl/simon_pkg.sv
// Shared types and helpers for the colour-sequence game datapath.
//   colour_t    : 2-bit colour code (RED, GREEN, BLUE, YELLOW)
//   MAX_ROUNDS  : depth of the stored colour sequence
//   LFSR_TAPS   : tap mask for x^16+x^14+x^13+x^11+1 (bits 15,13,12,10)
//   onehot()    : colour to lamp/key one-hot code (bit index = colour code)
//   lfsr_next() : one shift-left LFSR step, feedback into bit 0
//   next_colour(): low two bits the LFSR will hold after one step
package simon_pkg;

   typedef enum logic [1:0] {
      RED    = 2'd0,
      GREEN  = 2'd1,
      BLUE   = 2'd2,
      YELLOW = 2'd3
   } colour_t;

   localparam int unsigned MAX_ROUNDS = 32;
   localparam logic [15:0] LFSR_TAPS  = 16'hB400;

   function automatic logic [3:0] onehot(input colour_t c);
      return 4'b0001 << c;
   endfunction

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {v[14:0], ^(v & LFSR_TAPS)};
   endfunction

   function automatic colour_t next_colour(input logic [15:0] v);
      return colour_t'({v[0], ^(v & LFSR_TAPS)});
   endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (shift left, feedback into bit 0).
// Ports:
//   clk   : clock
//   reset : asynchronous active-high reset, value <= SEED_DEFAULT
//   load  : load seed (has priority over step)
//   seed  : value to load
//   step  : advance one step
//   value : current LFSR state
module lfsr16
   import simon_pkg::*;
#(
   parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] seed,
   input  logic        step,
   output logic [15:0] value
);

   logic [15:0] value_q, value_d;

   always_comb begin
      value_d = value_q;
      if (load)
         value_d = seed;
      else if (step)
         value_d = lfsr_next(value_q);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         value_q <= SEED_DEFAULT;
      else
         value_q <= value_d;
   end

   assign value = value_q;

endmodule

// File: rtl/seq_datapath.sv
// Datapath for a colour-sequence memory game: seed counter, LFSR-driven
// colour sequence store, player-key checking, lamp drive and a speed-scaled
// pulse timer.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   rst_seedgen   : clear free-running seed counter
//   start         : seed LFSR, clear sequence, restart timer
//   load_colour   : append one random colour (ignored when full or on start)
//   load_speed    : latch speed into speed level and restart timer
//   speed[2:0]    : requested speed level (period = BASE_PERIOD >> speed)
//   flash_clk     : light the expected colour
//   check_round   : items remaining; selects the expected sequence item
//   player_input  : one-hot colour keys, 0 = no key
//   pulse         : one-cycle timing tick
//   result        : last press matched the expected colour
//   leds          : one-hot lamp drive
// Build option: define SEQ_PLAYER_ECHO_EN to echo player keys on the lamps
// while flash_clk is low.
module seq_datapath
   import simon_pkg::*;
#(
   parameter int unsigned BASE_PERIOD  = 25000000,
   parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rst_seedgen,
   input  logic       start,
   input  logic       load_colour,
   input  logic       load_speed,
   input  logic [2:0] speed,
   input  logic       flash_clk,
   input  logic [5:0] check_round,
   input  logic [3:0] player_input,
   output logic       pulse,
   output logic       result,
   output logic [3:0] leds
);

   localparam int unsigned TW = (BASE_PERIOD > 1) ? $clog2(BASE_PERIOD) : 1;

   // Countdown start value for a level: max(1, BASE_PERIOD >> lvl) - 1.
   function automatic logic [TW-1:0] reload_val(input logic [2:0] lvl);
      logic [31:0] s;
      s = BASE_PERIOD >> lvl;
      if (s == 32'd0)
         s = 32'd1;
      return TW'(s - 32'd1);
   endfunction

   logic [15:0]   seed_cnt_q, seed_cnt_d;
   logic [5:0]    round_q, round_d;
   logic [2:0]    speed_lvl_q, speed_lvl_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          pulse_q, pulse_d;
   logic          result_q, result_d;
   logic [3:0]    leds_q, leds_d;

   colour_t       mem [MAX_ROUNDS];
   logic [15:0]   lfsr_value, lfsr_seed;
   logic          do_append;
   logic [4:0]    idx;
   logic          exp_valid;
   logic [3:0]    exp_onehot;

   lfsr16 #(.SEED_DEFAULT(SEED_DEFAULT)) u_lfsr (
      .clk   (clk),
      .reset (reset),
      .load  (start),
      .seed  (lfsr_seed),
      .step  (do_append),
      .value (lfsr_value)
   );

   always_comb begin
      seed_cnt_d = rst_seedgen ? '0 : seed_cnt_q + 16'd1;
      lfsr_seed  = (seed_cnt_q == '0) ? SEED_DEFAULT : seed_cnt_q;

      // Start wins over load_colour; a full sequence ignores further loads.
      do_append = load_colour && !start && (round_q != 6'(MAX_ROUNDS));
      round_d   = round_q;
      if (start)
         round_d = '0;
      else if (do_append)
         round_d = round_q + 6'd1;

      idx        = 5'(round_q - check_round);
      exp_valid  = (check_round != '0) && (check_round <= round_q);
      exp_onehot = onehot(mem[idx]);

      speed_lvl_d = load_speed ? speed : speed_lvl_q;
      // Pulse is registered one cycle behind the timer reaching zero.
      pulse_d = 1'b0;
      if (load_speed || start)
         timer_d = reload_val(speed_lvl_d);
      else if (timer_q == '0) begin
         timer_d = reload_val(speed_lvl_q);
         pulse_d = 1'b1;
      end else
         timer_d = timer_q - TW'(1);

      result_d = result_q;
      if (player_input != '0)
         result_d = exp_valid && (player_input == exp_onehot);

      leds_d = '0;
      if (flash_clk) begin
         if (exp_valid)
            leds_d = exp_onehot;
      end
`ifdef SEQ_PLAYER_ECHO_EN
      else
         leds_d = player_input;
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seed_cnt_q  <= '0;
         round_q     <= '0;
         speed_lvl_q <= '0;
         timer_q     <= TW'(BASE_PERIOD - 1);
         pulse_q     <= 1'b0;
         result_q    <= 1'b0;
         leds_q      <= '0;
      end else begin
         seed_cnt_q  <= seed_cnt_d;
         round_q     <= round_d;
         speed_lvl_q <= speed_lvl_d;
         timer_q     <= timer_d;
         pulse_q     <= pulse_d;
         result_q    <= result_d;
         leds_q      <= leds_d;
      end
   end

   // Sequence store is not reset; round_q = 0 keeps it unobservable.
   always_ff @(posedge clk) begin
      if (do_append && !reset)
         mem[round_q[4:0]] <= next_colour(lfsr_value);
   end

   assign pulse  = pulse_q;
   assign result = result_q;
   assign leds   = leds_q;

endmodule

// File: tb/tb_seq_datapath.sv
module tb_seq_datapath;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rst_seedgen = 1'b0;
   logic       start = 1'b0;
   logic       load_colour = 1'b0;
   logic       load_speed = 1'b0;
   logic [2:0] speed = 3'd0;
   logic       flash_clk = 1'b0;
   logic [5:0] check_round = 6'd0;
   logic [3:0] player_input = 4'd0;
   logic       pulse, result;
   logic [3:0] leds;

   int checks = 0;
   int failures = 0;

   seq_datapath #(.BASE_PERIOD(16), .SEED_DEFAULT(16'hACE1)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .rst_seedgen  (rst_seedgen),
      .start        (start),
      .load_colour  (load_colour),
      .load_speed   (load_speed),
      .speed        (speed),
      .flash_clk    (flash_clk),
      .check_round  (check_round),
      .player_input (player_input),
      .pulse        (pulse),
      .result       (result),
      .leds         (leds)
   );

   always #5 clk = ~clk;

   // Reference LFSR: x^16+x^14+x^13+x^11+1, shift left, feedback to bit 0.
   function automatic logic [15:0] m_step(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_pulse(output int n);
      n = -1;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (pulse === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic new_game();
      rst_seedgen = 1'b1; tick(); rst_seedgen = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      checks++;
      if ({pulse, result, leds} !== 6'b0) begin
         failures++;
         $display("FAIL reset_outputs got=%b exp=000000", {pulse, result, leds});
      end
      checks++;
      if (u_dut.u_lfsr.value !== 16'hACE1) begin
         failures++;
         $display("FAIL reset_lfsr got=%h exp=ace1", u_dut.u_lfsr.value);
      end
      reset = 1'b0;
   endtask

   task automatic test_pulse_timer();
      int n;
      wait_pulse(n);
      checks++;
      if (n !== 16) begin failures++; $display("FAIL pulse_first got=%0d exp=16", n); end
      wait_pulse(n);
      checks++;
      if (n !== 16) begin failures++; $display("FAIL pulse_period0 got=%0d exp=16", n); end
      load_speed = 1'b1; speed = 3'd2; tick(); load_speed = 1'b0;
      checks++;
      if (pulse !== 1'b0) begin failures++; $display("FAIL pulse_on_load got=%b exp=0", pulse); end
      wait_pulse(n);
      checks++;
      if (n !== 4) begin failures++; $display("FAIL pulse_after_load got=%0d exp=4", n); end
      for (int k = 0; k < 2; k++) begin
         wait_pulse(n);
         checks++;
         if (n !== 4) begin failures++; $display("FAIL pulse_period2 got=%0d exp=4", n); end
      end
   endtask

   task automatic test_lfsr_seed();
      new_game();
      checks++;
      if (u_dut.u_lfsr.value !== 16'hACE1) begin
         failures++;
         $display("FAIL seed_zero_default got=%h exp=ace1", u_dut.u_lfsr.value);
      end
      load_colour = 1'b1; tick(); load_colour = 1'b0;
      checks++;
      if (u_dut.u_lfsr.value !== 16'h59C3) begin
         failures++;
         $display("FAIL lfsr_step1 got=%h exp=59c3", u_dut.u_lfsr.value);
      end
      flash_clk = 1'b1; check_round = 6'd1; tick();
      checks++;
      if (leds !== 4'b1000) begin failures++; $display("FAIL mem0_yellow got=%b exp=1000", leds); end
      flash_clk = 1'b0; check_round = 6'd0;
   endtask

   // Sequence from ACE1: Y Y Y B R (lfsr 59C3 B387 670F CE1E 9C3C)
   task automatic test_sequence();
      logic [3:0] tbl [5];
      tbl = '{4'b0001, 4'b0100, 4'b1000, 4'b1000, 4'b1000};
      load_colour = 1'b1;
      repeat (4) tick();
      load_colour = 1'b0;
      checks++;
      if (u_dut.u_lfsr.value !== 16'h9C3C) begin
         failures++;
         $display("FAIL lfsr_step5 got=%h exp=9c3c", u_dut.u_lfsr.value);
      end
      flash_clk = 1'b1;
      for (int cr = 1; cr <= 5; cr++) begin
         check_round = 6'(cr); tick();
         checks++;
         if (leds !== tbl[cr-1]) begin
            failures++;
            $display("FAIL seq_leds cr=%0d got=%b exp=%b", cr, leds, tbl[cr-1]);
         end
      end
      check_round = 6'd6; tick();
      checks++;
      if (leds !== 4'b0000) begin failures++; $display("FAIL seq_cr_over got=%b exp=0000", leds); end
      flash_clk = 1'b0; check_round = 6'd2; player_input = 4'b0100; tick();
      checks++;
      if (result !== 1'b1) begin failures++; $display("FAIL result_blue got=%b exp=1", result); end
      player_input = 4'b0000; check_round = 6'd0;
   endtask

   task automatic test_result();
      new_game();
      load_colour = 1'b1; repeat (3) tick(); load_colour = 1'b0;
      check_round = 6'd2;
      player_input = 4'b1000; tick();
      checks++;
      if (result !== 1'b1) begin failures++; $display("FAIL result_match got=%b exp=1", result); end
      player_input = 4'b0001; tick();
      checks++;
      if (result !== 1'b0) begin failures++; $display("FAIL result_wrong got=%b exp=0", result); end
      player_input = 4'b1000; tick();
      player_input = 4'b0000; tick(); tick();
      checks++;
      if (result !== 1'b1) begin failures++; $display("FAIL result_hold got=%b exp=1", result); end
      player_input = 4'b1001; tick();
      checks++;
      if (result !== 1'b0) begin failures++; $display("FAIL result_multi got=%b exp=0", result); end
      player_input = 4'b1000; tick();
      check_round = 6'd5; tick();
      checks++;
      if (result !== 1'b0) begin failures++; $display("FAIL result_invalid got=%b exp=0", result); end
      player_input = 4'b0000;
   endtask

   task automatic test_flash_window();
      logic [3:0] exp_echo;
      flash_clk = 1'b1;
      check_round = 6'd0; tick();
      checks++;
      if (leds !== 4'b0000) begin failures++; $display("FAIL flash_cr0 got=%b exp=0000", leds); end
      check_round = 6'd5; tick();
      checks++;
      if (leds !== 4'b0000) begin failures++; $display("FAIL flash_cr5 got=%b exp=0000", leds); end
      check_round = 6'd3; tick();
      checks++;
      if (leds !== 4'b1000) begin failures++; $display("FAIL flash_cr3 got=%b exp=1000", leds); end
      flash_clk = 1'b0; player_input = 4'b0100; tick();
`ifdef SEQ_PLAYER_ECHO_EN
      exp_echo = 4'b0100;
`else
      exp_echo = 4'b0000;
`endif
      checks++;
      if (leds !== exp_echo) begin failures++; $display("FAIL echo got=%b exp=%b", leds, exp_echo); end
      player_input = 4'b0000; check_round = 6'd0; tick();
   endtask

   task automatic test_start_priority();
      rst_seedgen = 1'b1; tick(); rst_seedgen = 1'b0;
      start = 1'b1; load_colour = 1'b1; tick(); start = 1'b0; load_colour = 1'b0;
      checks++;
      if (u_dut.u_lfsr.value !== 16'hACE1) begin
         failures++;
         $display("FAIL start_prio_lfsr got=%h exp=ace1", u_dut.u_lfsr.value);
      end
      flash_clk = 1'b1; check_round = 6'd1; tick();
      checks++;
      if (leds !== 4'b0000) begin failures++; $display("FAIL start_prio_round got=%b exp=0000", leds); end
      flash_clk = 1'b0; check_round = 6'd0;
      rst_seedgen = 1'b1; tick(); rst_seedgen = 1'b0;
      tick();
      start = 1'b1; tick(); start = 1'b0;
      checks++;
      if (u_dut.u_lfsr.value !== 16'h0001) begin
         failures++;
         $display("FAIL seed_nonzero got=%h exp=0001", u_dut.u_lfsr.value);
      end
   endtask

   task automatic test_saturate(output logic [3:0] last_oh);
      logic [15:0] v;
      v = 16'hACE1;
      for (int i = 0; i < 32; i++) v = m_step(v);
      last_oh = 4'b0001 << v[1:0];
      new_game();
      load_colour = 1'b1; repeat (32) tick(); load_colour = 1'b0;
      checks++;
      if (u_dut.u_lfsr.value !== v) begin
         failures++;
         $display("FAIL sat_lfsr32 got=%h exp=%h", u_dut.u_lfsr.value, v);
      end
      load_colour = 1'b1; tick(); load_colour = 1'b0;
      checks++;
      if (u_dut.u_lfsr.value !== v) begin
         failures++;
         $display("FAIL sat_lfsr33 got=%h exp=%h", u_dut.u_lfsr.value, v);
      end
      flash_clk = 1'b1;
      check_round = 6'd1; tick();
      checks++;
      if (leds !== last_oh) begin failures++; $display("FAIL sat_mem31 got=%b exp=%b", leds, last_oh); end
      check_round = 6'd32; tick();
      checks++;
      if (leds !== 4'b1000) begin failures++; $display("FAIL sat_mem0 got=%b exp=1000", leds); end
      check_round = 6'd33; tick();
      checks++;
      if (leds !== 4'b0000) begin failures++; $display("FAIL sat_cr33 got=%b exp=0000", leds); end
      flash_clk = 1'b0; check_round = 6'd0;
   endtask

   task automatic test_reset_mid(input logic [3:0] last_oh);
      int n;
      flash_clk = 1'b1; check_round = 6'd1; player_input = last_oh; tick();
      player_input = 4'b0000;
      checks++;
      if ({result, leds} !== {1'b1, last_oh}) begin
         failures++;
         $display("FAIL pre_reset got=%b exp=%b", {result, leds}, {1'b1, last_oh});
      end
      wait_pulse(n);
      checks++;
      if (n < 1) begin failures++; $display("FAIL pre_reset_pulse got=%0d exp=1..40", n); end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({pulse, result, leds} !== 6'b0) begin
         failures++;
         $display("FAIL async_reset got=%b exp=000000", {pulse, result, leds});
      end
      load_colour = 1'b1; tick(); tick(); load_colour = 1'b0;
      reset = 1'b0;
      tick();
      checks++;
      if (leds !== 4'b0000) begin failures++; $display("FAIL reset_abort got=%b exp=0000", leds); end
      flash_clk = 1'b0; check_round = 6'd0;
   endtask

   initial begin
      logic [3:0] last_oh;
      test_reset();
      test_pulse_timer();
      test_lfsr_seed();
      test_sequence();
      test_result();
      test_flash_window();
      test_start_priority();
      test_saturate(last_oh);
      test_reset_mid(last_oh);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seq_datapath.md
SEQ_DATAPATH -- requirements
Module: seq_datapath

Interface
REQ-001 Parameter BASE_PERIOD, default 25000000, SHALL set the pulse period in clk cycles at speed level 0.
REQ-002 Parameter SEED_DEFAULT, default 16'hACE1, SHALL be the LFSR value used whenever a zero seed would be loaded.
REQ-003 clk  in  1  sole clock; every register SHALL update on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 rst_seedgen  in  1  strobe that clears the free-running seed counter.
REQ-006 start  in  1  strobe that seeds the LFSR and clears the stored sequence.
REQ-007 load_colour  in  1  strobe that appends one random colour.
REQ-008 load_speed  in  1  strobe that latches speed.
REQ-009 speed  in  3  requested speed level.
REQ-010 flash_clk  in  1  high while the current colour is to be lit.
REQ-011 check_round  in  6  items remaining; selects the sequence item.
REQ-012 player_input  in  4  one-hot colour keys; 0 means no key.
REQ-013 pulse  out  1  one-cycle timing tick.
REQ-014 result  out  1  last player press matched the expected colour.
REQ-015 leds  out  4  one-hot colour lamp drive.

Function
REQ-016 The seed counter SHALL be 16 bits, increment every cycle, wrap at FFFF->0000, and load 0 when rst_seedgen is high.
REQ-017 On start, the block SHALL load the LFSR with the seed counter value (SEED_DEFAULT if that value is 0) and set round_count to 0.
REQ-018 On load_colour without start, the LFSR SHALL advance one step (x^16+x^14+x^13+x^11+1, shift left, feedback into bit 0), and the new lfsr[1:0] SHALL be written to mem[round_count[4:0]] with round_count incremented.
REQ-019 While round_count==32, load_colour SHALL be ignored: no write, no LFSR step, no increment.
REQ-020 When start and load_colour are high in the same cycle, start SHALL take priority and load_colour SHALL be dropped.
REQ-021 Expected index SHALL be (round_count - check_round)[4:0]; the expectation SHALL be valid only when 1 <= check_round <= round_count.
REQ-022 Registered leds SHALL be onehot(mem[index]) one cycle after flash_clk is high with a valid expectation; otherwise leds SHALL be 0, subject to REQ-032.
REQ-023 Each cycle player_input != 0, result SHALL register (expectation valid AND player_input == onehot(mem[index])), giving 1-cycle latency.
REQ-024 While player_input == 0, result SHALL hold its value; non-one-hot input SHALL yield result 0.
REQ-025 The pulse timer SHALL reload to max(1, BASE_PERIOD >> speed_lvl) - 1, count down, assert pulse for exactly the one cycle in which it reaches 0, and then reload.
REQ-026 On load_speed, speed_lvl SHALL take speed and the timer SHALL reload, with no pulse in that cycle.
REQ-027 On start, the timer SHALL reload so that the first pulse arrives a full period later.

Reset
REQ-028 Asserting reset SHALL immediately force pulse=0, result=0, leds=0, round_count=0, seed counter=0, lfsr=SEED_DEFAULT, speed_lvl=0, and timer=BASE_PERIOD-1.
REQ-029 Memory contents SHALL NOT be reset; they SHALL be unobservable until written, because round_count=0.
REQ-030 Reset asserted mid-game SHALL abort the game, and no strobe SHALL act in any cycle while reset is high.

Configuration
REQ-031 Macro SEQ_PLAYER_ECHO_EN SHALL select player echo on the lamps.
REQ-032 With SEQ_PLAYER_ECHO_EN defined and flash_clk low, leds SHALL register player_input, so the lamps echo presses with 1-cycle latency.
REQ-033 Without SEQ_PLAYER_ECHO_EN, leds SHALL be 0 whenever flash_clk is low, and no echo logic SHALL be synthesised.

Structure
REQ-034 Package simon_pkg SHALL hold colour_t (2-bit enum RED, GREEN, BLUE, YELLOW), MAX_ROUNDS=32, LFSR_TAPS, and function onehot(colour_t).
REQ-035 The LFSR SHALL be a separate sub-module lfsr16 (ports: clk, reset, load, seed, step, value), and all other logic SHALL be in seq_datapath.

Verification
REQ-036 BASE_PERIOD=16, speed 0 then load_speed with speed=2 -> pulse every 16 cycles, then every 4 cycles, starting 4 cycles after load_speed.
REQ-037 Seed counter=0 at start, one load_colour -> LFSR steps from ACE1 to 59C3, and mem[0]=2'b11 (YELLOW).
REQ-038 33 load_colour strobes after start -> round_count saturates at 32, and the 33rd strobe leaves lfsr and mem unchanged.
REQ-039 round_count=3, check_round=2, player_input=onehot(mem[1]) -> result=1 next cycle; wrong key -> result=0; keys released -> result holds.
REQ-040 flash_clk=1 with check_round=0 or check_round=5 > round_count=3 -> leds=0; with SEQ_PLAYER_ECHO_EN, flash_clk=0 and player_input=4'b0100 -> leds=4'b0100.
REQ-041 reset pulsed mid-pulse-period and mid-flash -> all outputs 0 immediately, without waiting for a clock edge.
